// File: rtl/waveform_pkg.sv
// Shared types and defaults for the waveform sample design.
package waveform_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    LOCKED = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam int WIDTH_DEF     = 32;
  localparam int ERR_CNT_W_DEF = 16;

endpackage

// File: rtl/counter_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/counter_stream_checker.sv
// Locks onto an up/down counter pair stream and reports mismatches against
// the predicted next value.
module counter_stream_checker
  import waveform_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ERR_CNT_W   = ERR_CNT_W_DEF,
  parameter int RESYNC_GOOD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  input  logic [WIDTH-1:0]     in_count_rev,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_vld,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_got
);

  localparam int GOOD_W = $clog2(RESYNC_GOOD + 1);
  localparam logic [WIDTH-1:0]  ONE      = 1;
  localparam logic [GOOD_W-1:0] GOOD_ONE = 1;
  localparam logic [GOOD_W-1:0] GOOD_TGT = RESYNC_GOOD[GOOD_W-1:0];

  state_t            state;
  logic [WIDTH-1:0]  exp_cnt;
  logic [GOOD_W-1:0] good_cnt;

  logic [WIDTH-1:0]  pair_sum;
  logic [WIDTH-1:0]  exp_neg;
  logic [GOOD_W-1:0] good_nxt;
  logic              consistent;
  logic              match;
  logic              err_event;

  // A sample matches only if both halves of the pair agree with the prediction.
  assign pair_sum   = in_count + in_count_rev;
  assign exp_neg    = '0 - exp_cnt;
  assign consistent = (pair_sum == '0);
  assign match      = (in_count == exp_cnt) && (in_count_rev == exp_neg);
  assign good_nxt   = good_cnt + GOOD_ONE;
  assign err_event  = in_valid && !clear && (state == LOCKED) && !match;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SEEK;
      exp_cnt       <= '0;
      good_cnt      <= '0;
      err_pulse     <= 1'b0;
      first_err_vld <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        state         <= SEEK;
        good_cnt      <= '0;
        first_err_vld <= 1'b0;
        first_err_exp <= '0;
        first_err_got <= '0;
      end else if (in_valid) begin
        case (state)
          SEEK: begin
            if (consistent) begin
              exp_cnt <= in_count + ONE;
              state   <= LOCKED;
            end
          end
          LOCKED: begin
            if (match) begin
              exp_cnt <= exp_cnt + ONE;
            end else begin
              err_pulse <= 1'b1;
              if (!first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_exp <= exp_cnt;
                first_err_got <= in_count;
              end
              exp_cnt  <= in_count + ONE;
              good_cnt <= '0;
              state    <= RESYNC;
            end
          end
          RESYNC: begin
            // Mismatches here only reseed; they are fallout of the original error.
            if (match) begin
              exp_cnt <= exp_cnt + ONE;
              if (good_nxt == GOOD_TGT) begin
                good_cnt <= '0;
                state    <= LOCKED;
              end else begin
                good_cnt <= good_nxt;
              end
            end else begin
              exp_cnt  <= in_count + ONE;
              good_cnt <= '0;
            end
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_event),
    .clr  (clear),
    .q    (err_count)
  );

endmodule

// File: tb/tb_counter_stream_checker.sv
// Directed scoreboard bench for counter_stream_checker (ERR_CNT_W=4 build).
module tb_counter_stream_checker;

  localparam int W  = 32;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_count = '0;
  logic [W-1:0]  in_count_rev = '0;
  logic          clear = 1'b0;
  logic          locked;
  logic          err_pulse;
  logic [EW-1:0] err_count;
  logic          first_err_vld;
  logic [W-1:0]  first_err_exp;
  logic [W-1:0]  first_err_got;

  always #5 clk = ~clk;

  counter_stream_checker #(
    .WIDTH(W),
    .ERR_CNT_W(EW),
    .RESYNC_GOOD(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_count     (in_count),
    .in_count_rev (in_count_rev),
    .clear        (clear),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .first_err_vld(first_err_vld),
    .first_err_exp(first_err_exp),
    .first_err_got(first_err_got)
  );

  typedef struct {
    logic        l;
    logic        p;
    int          cnt;
    logic        fv;
    logic [31:0] fe;
    logic [31:0] fg;
  } exp_t;

  exp_t q[$];
  int n_applied = 0;
  int n_miscmp  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_applied++;
    if (act !== req) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] neg(input logic [31:0] x);
    return '0 - x;
  endfunction

  function automatic int sat15(input int k);
    return (k > 15) ? 15 : k;
  endfunction

  task automatic step(input logic v, input logic [31:0] c, input logic [31:0] r, input logic cl,
                      input logic el, input logic ep, input int ec,
                      input logic efv, input logic [31:0] efe, input logic [31:0] efg);
    exp_t x;
    @(negedge clk);
    in_valid = v; in_count = c; in_count_rev = r; clear = cl;
    x.l = el; x.p = ep; x.cnt = ec; x.fv = efv; x.fe = efe; x.fg = efg;
    q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  // Monitor: status outputs settle one cycle after each sampled vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked",        32'(locked),        32'(e.l));
        chk("err_pulse",     32'(err_pulse),     32'(e.p));
        chk("err_count",     32'(err_count),     e.cnt);
        chk("first_err_vld", 32'(first_err_vld), 32'(e.fv));
        chk("first_err_exp", first_err_exp,      e.fe);
        chk("first_err_got", first_err_got,      e.fg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    #1 rst_n = 1'b0;
    #10;
    chk("rst locked",    32'(locked), 0);
    chk("rst err_pulse", 32'(err_pulse), 0);
    chk("rst err_count", 32'(err_count), 0);
    chk("rst fvld",      32'(first_err_vld), 0);
    chk("rst fexp",      first_err_exp, 0);
    chk("rst fgot",      first_err_got, 0);
    @(negedge clk) rst_n = 1'b1;

    // Lock-on: inconsistent pair ignored, then 5/-5 locks
    step(1, 5, 7,        0, 0, 0, 0, 0, 0, 0);
    step(1, 5, neg(5),   0, 1, 0, 0, 0, 0, 0);
    step(1, 6, neg(6),   0, 1, 0, 0, 0, 0, 0);
    step(1, 7, neg(7),   0, 1, 0, 0, 0, 0, 0);
    step(0, 32'hdead, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 8, neg(8),   0, 1, 0, 0, 0, 0, 0);

    // Wrap through all-ones
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'hFFFFFFFE, neg(32'hFFFFFFFE), 0, 1, 0, 0, 0, 0, 0);
    step(1, 32'hFFFFFFFF, neg(32'hFFFFFFFF), 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0,         0, 1, 0, 0, 0, 0, 0);
    step(1, 1, neg(1),    0, 1, 0, 0, 0, 0, 0);

    // First error at exp=10, got 12, then resync over 13..16
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 9,  neg(9),  0, 1, 0, 0, 0, 0, 0);
    step(1, 12, neg(12), 0, 0, 1, 1, 1, 10, 12);
    step(1, 13, neg(13), 0, 0, 0, 1, 1, 10, 12);
    step(1, 14, neg(14), 0, 0, 0, 1, 1, 10, 12);
    step(1, 15, neg(15), 0, 0, 0, 1, 1, 10, 12);
    step(1, 16, neg(16), 0, 1, 0, 1, 1, 10, 12);

    // Second error, then mismatch inside RESYNC is not counted
    step(1, 20, neg(20), 0, 0, 1, 2, 1, 10, 12);
    step(1, 30, neg(30), 0, 0, 0, 2, 1, 10, 12);
    step(1, 31, neg(31), 0, 0, 0, 2, 1, 10, 12);
    step(1, 32, neg(32), 0, 0, 0, 2, 1, 10, 12);
    step(1, 33, neg(33), 0, 0, 0, 2, 1, 10, 12);
    step(1, 34, neg(34), 0, 1, 0, 2, 1, 10, 12);

    // Saturation: 19 counted errors on a 4-bit counter
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 100, neg(100), 0, 1, 0, 0, 0, 0, 0);
    e = 101;
    for (int k = 1; k <= 19; k++) begin
      step(1, e + 5, neg(e + 5), 0, 0, 1, sat15(k), 1, 101, 106);
      for (int j = 0; j < 4; j++)
        step(1, e + 6 + j, neg(e + 6 + j), 0, (j == 3), 0, sat15(k), 1, 101, 106);
      e = e + 10;
    end
    // Correct count but wrong mirror is an error too
    step(1, e, 0, 0, 0, 1, 15, 1, 101, 106);
    for (int j = 1; j <= 4; j++)
      step(1, e + j, neg(e + j), 0, (j == 4), 0, 15, 1, 101, 106);
    e = e + 5;

    // Clear wins over a simultaneous mismatching sample
    step(1, 999, neg(999), 1, 0, 0, 0, 0, 0, 0);
    step(1, 50, neg(50),   0, 1, 0, 0, 0, 0, 0);
    step(1, 60, neg(60),   0, 0, 1, 1, 1, 51, 60);

    // Asynchronous reset mid-stream
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst locked",    32'(locked), 0);
    chk("arst err_pulse", 32'(err_pulse), 0);
    chk("arst err_count", 32'(err_count), 0);
    chk("arst fvld",      32'(first_err_vld), 0);
    chk("arst fexp",      first_err_exp, 0);
    chk("arst fgot",      first_err_got, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1, 70, neg(70), 0, 1, 0, 0, 0, 0, 0);
    idle();
    repeat (3) @(posedge clk);
    #2;
    chk("queue drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule
